// File: rtl/tetris_vga_pkg.sv
// tetris_vga_pkg: default VGA timing, grid geometry and colours shared by the Tetris renderer
package tetris_vga_pkg;
  localparam int DEF_H_ACTIVE = 640, DEF_H_FP = 16, DEF_H_SYNC = 96, DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480, DEF_V_FP = 10, DEF_V_SYNC = 2, DEF_V_BP = 33;
  localparam int DEF_CELL = 20, DEF_GRID_X0 = 220, DEF_GRID_Y0 = 40;
  localparam int ROWS = 20, COLS = 10;
  typedef logic [11:0] rgb444_t;
  localparam rgb444_t COL_BG      = 12'h000;
  localparam rgb444_t COL_BORDER  = 12'h888;
  localparam rgb444_t COL_OUTLINE = 12'h222;
  localparam rgb444_t COL_CELL    = 12'hFFF;
  localparam rgb444_t COL_DEAD    = 12'hF00;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with raw sync, data-enable and frame-start pulse
module vga_timing
  import tetris_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_DE   = 10'(H_ACTIVE);
  localparam logic [9:0] V_DE   = 10'(V_ACTIVE);
  logic h_end, v_end;
  always_comb begin
    h_end = hcount == H_LAST;
    v_end = vcount == V_LAST;
    hsync = !(hcount >= HS_LO && hcount < HS_HI);
    vsync = !(vcount >= VS_LO && vcount < VS_HI);
    de    = hcount < H_DE && vcount < V_DE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_end ? '0 : hcount + 10'd1;
      vcount      <= !h_end ? vcount : v_end ? '0 : vcount + 10'd1;
      frame_start <= h_end && v_end;
    end
endmodule

// File: rtl/tetris_grid_renderer.sv
// tetris_grid_renderer: renders a once-per-frame snapshot of the playfield as a bordered cell grid on a VGA raster
module tetris_grid_renderer
  import tetris_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CELL     = DEF_CELL,
  parameter int GRID_X0  = DEF_GRID_X0,
  parameter int GRID_Y0  = DEF_GRID_Y0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [21:0][9:0] display_array_i,
  input  logic             gameover_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output rgb444_t          rgb_o,
  output logic             frame_start_o
);
  localparam logic [9:0] X_L    = 10'(GRID_X0 - 1);
  localparam logic [9:0] X_0    = 10'(GRID_X0);
  localparam logic [9:0] X_1    = 10'(GRID_X0 + COLS * CELL - 1);
  localparam logic [9:0] X_R    = 10'(GRID_X0 + COLS * CELL);
  localparam logic [9:0] Y_T    = 10'(GRID_Y0 - 1);
  localparam logic [9:0] Y_0    = 10'(GRID_Y0);
  localparam logic [9:0] Y_1    = 10'(GRID_Y0 + ROWS * CELL - 1);
  localparam logic [9:0] Y_B    = 10'(GRID_Y0 + ROWS * CELL);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_CAP  = 10'(V_ACTIVE);
  localparam logic [4:0] PX_LAST = 5'(CELL - 1);
  localparam logic [3:0] C_LAST  = 4'(COLS - 1);
  localparam logic [4:0] R_LAST  = 5'(ROWS - 1);
  logic [9:0] hcount, vcount;
  logic hs, vs, de;
  logic [19:0][9:0] snapshot;
  logic [3:0] cell_x;
  logic [4:0] cell_y, px_x, px_y;
  logic h_in, v_in, in_grid, border;
  logic hs1, vs1, de1, border1, fill1, edge1;
  logic unused_rows;
  assign unused_rows = ^display_array_i[21:20];
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hs),
    .vsync       (vs),
    .de          (de),
    .frame_start (frame_start_o)
  );
  always_comb begin
    h_in    = hcount >= X_0 && hcount <= X_1;
    v_in    = vcount >= Y_0 && vcount <= Y_1;
    in_grid = h_in && v_in;
    border  = ((hcount == X_L || hcount == X_R) && vcount >= Y_T && vcount <= Y_B)
           || ((vcount == Y_T || vcount == Y_B) && hcount >= X_L && hcount <= X_R);
  end
  always_ff @(posedge clk)
    if (reset) begin
      cell_x   <= '0;
      px_x     <= '0;
      cell_y   <= '0;
      px_y     <= '0;
      snapshot <= '0;
    end else begin
      if (hcount == X_L) begin
        cell_x <= '0;
        px_x   <= '0;
      end else if (h_in) begin
        px_x <= px_x == PX_LAST ? '0 : px_x + 5'd1;
        if (px_x == PX_LAST && cell_x != C_LAST) cell_x <= cell_x + 4'd1;
      end
      if (hcount == H_LAST && vcount == Y_T) begin
        cell_y <= '0;
        px_y   <= '0;
      end else if (hcount == H_LAST && v_in) begin
        px_y <= px_y == PX_LAST ? '0 : px_y + 5'd1;
        if (px_y == PX_LAST && cell_y != R_LAST) cell_y <= cell_y + 5'd1;
      end
      if (hcount == '0 && vcount == V_CAP) snapshot <= display_array_i[19:0];
    end
  always_ff @(posedge clk)
    if (reset) begin
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      de1     <= 1'b0;
      border1 <= 1'b0;
      fill1   <= 1'b0;
      edge1   <= 1'b0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      de_o    <= 1'b0;
      rgb_o   <= COL_BG;
    end else begin
      hs1     <= hs;
      vs1     <= vs;
      de1     <= de;
      border1 <= border;
      fill1   <= in_grid && snapshot[cell_y][cell_x];
      edge1   <= px_x == PX_LAST || px_y == PX_LAST;
      hsync_o <= hs1;
      vsync_o <= vs1;
      de_o    <= de1;
      rgb_o   <= !de1 ? COL_BG : border1 ? COL_BORDER : fill1 && edge1 ? COL_OUTLINE
               : fill1 ? (gameover_i ? COL_DEAD : COL_CELL) : COL_BG;
    end
endmodule
